// File: rtl/light_pkg.sv
// light_pkg
//    Shared types and helpers for the three-colour light sequencer.
//    - phase_e : light phase (RED, GREEN, YELLOW)
//    - mode_e  : board-switch mode (NORMAL, FLASH, ALLRED)
//    - BLANK   : active-low segment pattern with every segment off
//    - seg7    : BCD digit -> active-low {dp,g,f,e,d,c,b,a} pattern
//    - to_bcd  : integer -> four packed BCD nibbles (constant folding only)
//    - next_phase : RED -> GREEN -> YELLOW -> RED
package light_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } phase_e;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      FLASH  = 2'd1,
      ALLRED = 2'd2
   } mode_e;

   localparam logic [7:0] BLANK = 8'hFF;

   // Common-anode patterns, decimal point always off.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return BLANK;
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned t;
      r = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         RED:     return GREEN;
         GREEN:   return YELLOW;
         default: return RED;
      endcase
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan
//    Multiplexed N-digit seven-segment driver. Steps a digit index every
//    SCAN_DIV cycles (units first), blanks leading zeros above the units
//    digit, and registers SEG and COM together so they always change on
//    the same edge.
//    Ports:
//       clk_i   system clock
//       rst_ni  asynchronous active-low reset
//       bcd_i   NUM_DIGITS packed BCD nibbles, nibble 0 = units
//       blank_i force the whole display dark (COM keeps scanning)
//       seg_o   active-low segments {dp,g,f,e,d,c,b,a}
//       com_o   active-low one-hot digit enable, bit 0 = units
module seg7_scan
   import light_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 50_000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] bcd_i,
   input  logic                    blank_i,
   output logic [7:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   com_o
);
   // Degenerate divisors still need at least one counter bit.
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] com_q, com_d;

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      com_d = '1;
      seg_d = BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            com_d[i] = 1'b0;
            // A higher digit is a leading zero when it and everything above it is zero.
            if (!blank_i && (i == 0 || (bcd_i >> (4 * i)) != '0))
               seg_d = seg7(bcd_i[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_q      <= BLANK;
         com_q      <= '1;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         com_q      <= com_d;
      end
   end

   assign seg_o = seg_q;
   assign com_o = com_q;

endmodule

// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl
//    Red -> green -> yellow light sequencer with per-phase durations in
//    seconds, a prescaled one-second tick, pause/skip keys and a board
//    switch selecting normal, night-flash or all-red-hold operation.
//    Remaining seconds are shown on a multiplexed seven-segment display.
//    Optional macro KEY_DEBOUNCE_EN: keys must be stable for DEB_CYCLES
//    cycles before their level reaches the edge detector.
//    Ports:
//       Sys_CLK  system clock
//       Sys_RST  asynchronous active-low reset
//       Key      [0] pause toggle, [1] skip phase (active-high)
//       Switch   00 normal, 01 night flash, 1x all-red hold
//       LED      [0] red, [1] yellow, [2] green, [3] paused
//       SEG      active-low segments {dp,g,f,e,d,c,b,a}
//       COM      active-low one-hot digit enable, bit 0 = units
module light_seq_ctrl
   import light_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int SCAN_DIV   = 50_000,
   parameter int NUM_DIGITS = 2,
   parameter int RED_T      = 30,
   parameter int GREEN_T    = 25,
   parameter int YELLOW_T   = 5,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic                  Sys_CLK,
   input  logic                  Sys_RST,
   input  logic [1:0]            Key,
   input  logic [1:0]            Switch,
   output logic [3:0]            LED,
   output logic [7:0]            SEG,
   output logic [NUM_DIGITS-1:0] COM
);
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int MAX_T  = 10 ** NUM_DIGITS - 1;

   localparam logic [BCD_W-1:0] RED_BCD    = BCD_W'(to_bcd(RED_T));
   localparam logic [BCD_W-1:0] GREEN_BCD  = BCD_W'(to_bcd(GREEN_T));
   localparam logic [BCD_W-1:0] YELLOW_BCD = BCD_W'(to_bcd(YELLOW_T));
   localparam logic [BCD_W-1:0] ONE_BCD    = BCD_W'(1);

   generate
      if (TICK_DIV < 2 || SCAN_DIV < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 4 || DEB_CYCLES < 1) begin : g_bad_cfg
         $error("light_seq_ctrl: divider, digit count or debounce window out of range");
      end
      if (RED_T < 1 || RED_T > MAX_T || GREEN_T < 1 || GREEN_T > MAX_T ||
          YELLOW_T < 1 || YELLOW_T > MAX_T) begin : g_bad_dur
         $error("light_seq_ctrl: phase duration does not fit the display");
      end
   endgenerate

   logic [1:0]       key_s1_q, key_s2_q, key_prev_q, key_edge_q, key_lvl;
   logic [1:0]       sw_s1_q, sw_s2_q;
   mode_e            sw_mode, mode_q, mode_prev_q;
   phase_e           phase_q, phase_d, phase_nxt;
   logic [BCD_W-1:0] rem_q, rem_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             paused_q, paused_d, flash_q, flash_d, tick_wrap;
   logic [3:0]       led_q, led_d;
   logic             disp_blank;

`ifdef KEY_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         logic [DEB_W-1:0] cnt_q;
         logic             lvl_q;
         // Accept a new level only after it has differed from the accepted one for a full window.
         always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
            if (!Sys_RST) begin
               cnt_q <= '0;
               lvl_q <= 1'b0;
            end else if (key_s2_q[gi] == lvl_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
               cnt_q <= '0;
               lvl_q <= key_s2_q[gi];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         assign key_lvl[gi] = lvl_q;
      end
   endgenerate
`else
   assign key_lvl = key_s2_q;
`endif

   assign sw_mode    = sw_s2_q[1] ? ALLRED : (sw_s2_q[0] ? FLASH : NORMAL);
   assign phase_nxt  = next_phase(phase_q);
   assign tick_wrap  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign disp_blank = (mode_q != NORMAL);

   function automatic logic [BCD_W-1:0] dur_bcd(input phase_e p);
      case (p)
         RED:     return RED_BCD;
         GREEN:   return GREEN_BCD;
         default: return YELLOW_BCD;
      endcase
   endfunction

   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Priority inside normal mode: re-entry reload, then skip, then the tick.
   always_comb begin
      phase_d    = phase_q;
      rem_d      = rem_q;
      tick_cnt_d = tick_cnt_q;
      paused_d   = paused_q;
      flash_d    = flash_q;
      led_d      = led_q;

      if (key_edge_q[0])
         paused_d = ~paused_q;

      unique case (mode_q)
         NORMAL: begin
            if (mode_prev_q != NORMAL) begin
               phase_d    = RED;
               rem_d      = RED_BCD;
               tick_cnt_d = '0;
               paused_d   = 1'b0;
            end else if (key_edge_q[1]) begin
               phase_d    = phase_nxt;
               rem_d      = dur_bcd(phase_nxt);
               tick_cnt_d = '0;
            end else if (!paused_q) begin
               tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
               if (tick_wrap) begin
                  if (rem_q == ONE_BCD) begin
                     phase_d = phase_nxt;
                     rem_d   = dur_bcd(phase_nxt);
                  end else begin
                     rem_d = bcd_dec(rem_q);
                  end
               end
            end
            led_d = {paused_d, phase_d == GREEN, phase_d == YELLOW, phase_d == RED};
         end
         FLASH: begin
            // Restart the prescaler on entry so yellow stays lit a full second first.
            if (mode_prev_q != FLASH) begin
               flash_d    = 1'b1;
               tick_cnt_d = '0;
            end else begin
               tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
               if (tick_wrap)
                  flash_d = ~flash_q;
            end
            led_d = {paused_d, 1'b0, flash_d, 1'b0};
         end
         default: begin
            led_d = {paused_d, 3'b001};
         end
      endcase
   end

   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         key_s1_q    <= '0;
         key_s2_q    <= '0;
         key_prev_q  <= '0;
         key_edge_q  <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         mode_q      <= NORMAL;
         mode_prev_q <= NORMAL;
         phase_q     <= RED;
         rem_q       <= RED_BCD;
         tick_cnt_q  <= '0;
         paused_q    <= 1'b0;
         flash_q     <= 1'b0;
         led_q       <= 4'b0001;
      end else begin
         key_s1_q    <= Key;
         key_s2_q    <= key_s1_q;
         key_prev_q  <= key_lvl;
         key_edge_q  <= key_lvl & ~key_prev_q;
         sw_s1_q     <= Switch;
         sw_s2_q     <= sw_s1_q;
         mode_q      <= sw_mode;
         mode_prev_q <= mode_q;
         phase_q     <= phase_d;
         rem_q       <= rem_d;
         tick_cnt_q  <= tick_cnt_d;
         paused_q    <= paused_d;
         flash_q     <= flash_d;
         led_q       <= led_d;
      end
   end

   assign LED = led_q;

   // Feeding next-state remaining keeps SEG in step with LED on every edge.
   seg7_scan #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan (
      .clk_i   (Sys_CLK),
      .rst_ni  (Sys_RST),
      .bcd_i   (rem_d),
      .blank_i (disp_blank),
      .seg_o   (SEG),
      .com_o   (COM)
   );

endmodule

// File: tb/tb_light_seq_ctrl.sv
module tb_light_seq_ctrl;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
   localparam int ND       = 2;
   localparam int RED_T    = 3;
   localparam int GREEN_T  = 2;
   localparam int YELLOW_T = 1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] key   = 2'b00;
   logic [1:0] sw    = 2'b00;
   logic [3:0] led;
   logic [7:0] seg;
   logic [1:0] com;

   always #5 clk = ~clk;

   light_seq_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .SCAN_DIV   (SCAN_DIV),
      .NUM_DIGITS (ND),
      .RED_T      (RED_T),
      .GREEN_T    (GREEN_T),
      .YELLOW_T   (YELLOW_T),
      .DEB_CYCLES (4)
   ) dut (
      .Sys_CLK (clk),
      .Sys_RST (rst_n),
      .Key     (key),
      .Switch  (sw),
      .LED     (led),
      .SEG     (seg),
      .COM     (com)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // Phases 0=red 1=green 2=yellow; modes 0=normal 1=flash 2=all-red.
   // Inputs take effect three edges after they are sampled.
   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int  m_phase, m_rem, m_tick, m_mode, m_idx, m_edges;
   bit  m_flash, m_paused;
   logic [1:0] kh [5];
   logic [1:0] sh [5];

   function automatic int dur(input int p);
      return (p == 0) ? RED_T : ((p == 1) ? GREEN_T : YELLOW_T);
   endfunction

   function automatic int mode_of(input logic [1:0] s);
      return s[1] ? 2 : (s[0] ? 1 : 0);
   endfunction

   task automatic model_reset();
      m_phase = 0; m_rem = RED_T; m_tick = 0; m_mode = 0;
      m_idx = 0; m_edges = 0; m_flash = 0; m_paused = 0;
      for (int i = 0; i < 5; i++) begin
         kh[i] = 2'b00;
         sh[i] = 2'b00;
      end
   endtask

   task automatic model_edge();
      int  prev_mode;
      bit  was_paused, pause_ev, skip_ev;
      for (int i = 4; i > 0; i--) begin
         kh[i] = kh[i-1];
         sh[i] = sh[i-1];
      end
      kh[0] = key;
      sh[0] = sw;
      pause_ev   = kh[3][0] && !kh[4][0];
      skip_ev    = kh[3][1] && !kh[4][1];
      m_mode     = mode_of(sh[3]);
      prev_mode  = mode_of(sh[4]);
      was_paused = m_paused;
      if (pause_ev) m_paused = !m_paused;
      if (m_mode == 0) begin
         if (prev_mode != 0) begin
            m_phase = 0; m_rem = RED_T; m_tick = 0; m_paused = 0;
         end else if (skip_ev) begin
            m_phase = (m_phase + 1) % 3; m_rem = dur(m_phase); m_tick = 0;
         end else if (!was_paused) begin
            m_tick = (m_tick + 1) % TICK_DIV;
            if (m_tick == 0) begin
               if (m_rem == 1) begin
                  m_phase = (m_phase + 1) % 3;
                  m_rem   = dur(m_phase);
               end else begin
                  m_rem = m_rem - 1;
               end
            end
         end
      end else if (m_mode == 1) begin
         if (prev_mode != 1) begin
            m_flash = 1; m_tick = 0;
         end else begin
            m_tick = (m_tick + 1) % TICK_DIV;
            if (m_tick == 0) m_flash = !m_flash;
         end
      end
      m_idx   = (m_edges / SCAN_DIV) % ND;
      m_edges = m_edges + 1;
   endtask

   function automatic logic [3:0] exp_led();
      logic [3:0] l;
      if (m_mode == 0)      l = {m_paused, m_phase == 1, m_phase == 2, m_phase == 0};
      else if (m_mode == 1) l = {m_paused, 1'b0, m_flash, 1'b0};
      else                  l = {m_paused, 3'b001};
      return l;
   endfunction

   function automatic logic [7:0] exp_seg();
      int p = 1;
      for (int i = 0; i < m_idx; i++) p = p * 10;
      if (m_mode != 0) return 8'hFF;
      if (m_idx > 0 && m_rem < p) return 8'hFF;
      return seg_tab[(m_rem / p) % 10];
   endfunction

   function automatic logic [1:0] exp_com();
      logic [1:0] one = 2'b01;
      return ~(one << m_idx);
   endfunction

   // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
   task automatic cycle(input logic [1:0] k, input logic [1:0] s);
      key = k;
      sw  = s;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_val("led", 32'(led), 32'(exp_led()));
      check_val("seg", 32'(seg), 32'(exp_seg()));
      check_val("com", 32'(com), 32'(exp_com()));
   endtask

   task automatic run_until(input int p, input int r);
      bit hit = 0;
      for (int i = 0; i < 80 && !hit; i++) begin
         if (m_mode == 0 && m_phase == p && (r < 0 || m_rem == r)) hit = 1;
         else cycle(2'b00, 2'b00);
      end
      check_val("reach_phase", 32'(hit), 32'd1);
   endtask

   initial begin
      logic [1:0] rk, rs;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_led", 32'(led), 32'h1);
      check_val("rst_seg", 32'(seg), 32'hFF);
      check_val("rst_com", 32'(com), 32'h3);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // full red/green/yellow cycle
      repeat (24) cycle(2'b00, 2'b00);

      // pause at red 2, hold, resume
      run_until(0, 2);
      cycle(2'b01, 2'b00);
      repeat (20) cycle(2'b00, 2'b00);
      cycle(2'b01, 2'b00);
      repeat (10) cycle(2'b00, 2'b00);

      // skip during green
      run_until(1, -1);
      cycle(2'b10, 2'b00);
      repeat (6) cycle(2'b00, 2'b00);

      // night flash, then back to normal
      repeat (15) cycle(2'b00, 2'b01);
      repeat (8) cycle(2'b00, 2'b00);

      // all-red hold with a pause toggle, then back to normal
      repeat (4) cycle(2'b00, 2'b10);
      cycle(2'b01, 2'b11);
      repeat (8) cycle(2'b00, 2'b11);
      repeat (8) cycle(2'b00, 2'b00);

      // randomized keys and switch
      rs = 2'b00;
      repeat (500) begin
         rk = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 40) == 0) rs = 2'($urandom);
         cycle(rk, rs);
      end

      // asynchronous reset in the middle of yellow
      repeat (6) cycle(2'b00, 2'b00);
      run_until(2, -1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_led", 32'(led), 32'h1);
      check_val("async_rst_seg", 32'(seg), 32'hFF);
      check_val("async_rst_com", 32'(com), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (12) cycle(2'b00, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
